// File: rtl/tero_pkg.sv
// Shared types and constants for the TERO PUF evaluation sequencer.
package tero_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_RESET  = 3'd2,
        ST_EVAL   = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_WAIT   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Default array configuration
    localparam int DEF_NUM_LOOPS   = 8;
    localparam int DEF_REPETITIONS = 4;
    localparam int DEF_EVAL_TIME   = 16;
    localparam int DEF_RESET_TIME  = 2;

    // Index and repetition counter widths for the default configuration
    localparam int LOOP_W = $clog2(DEF_NUM_LOOPS);
    localparam int REP_W  = $clog2(DEF_REPETITIONS + 1);

    // Averaging-block handshake: level of next_enable meaning "ready for next evaluation"
    localparam logic AVG_READY = 1'b1;

    // Phase timer width; at least one bit so short phases still get a counter
    function automatic int timer_width(input int eval_time, input int reset_time);
        int longest;
        longest = (eval_time > reset_time) ? eval_time : reset_time;
        return (longest <= 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/tero_phase_timer.sv
// Loadable down-counter timing the RESET and EVAL phases.
// zero flags terminal count; the counter holds at zero until reloaded.
module tero_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over counting down; stop at terminal count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/tero_sequencer.sv
// Evaluation sequencer for the TERO PUF array.
// Walks every loop selected by the latched challenge and runs each one
// through REPETITIONS reset/evaluate/sample cycles, handshaking each
// sample with the averaging block.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for start after reset or abort
// ST_SCAN   | testing chal_q[idx], one loop index per cycle
// ST_RESET  | reset_puf held for RESET_TIME cycles
// ST_EVAL   | enable_puf held for EVAL_TIME cycles
// ST_SAMPLE | one-cycle add_response_puf to the averaging block
// ST_WAIT   | waiting for next_enable from the averaging block
// ST_DONE   | run complete, done held until start/abort/reset
module tero_sequencer
    import tero_pkg::*;
#(
    parameter int NUM_LOOPS   = DEF_NUM_LOOPS,
    parameter int REPETITIONS = DEF_REPETITIONS,
    parameter int EVAL_TIME   = DEF_EVAL_TIME,
    parameter int RESET_TIME  = DEF_RESET_TIME
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic [NUM_LOOPS-1:0]               challenge,
    input  logic                               next_enable,
    output logic                               busy,
    output logic                               done,
    output logic                               reset_puf,
    output logic                               enable_puf,
    output logic [$clog2(NUM_LOOPS)-1:0]       select_puf,
    output logic                               add_response_puf,
    output logic [$clog2(REPETITIONS+1)-1:0]   rep_index,
    output logic                               last_rep
);

    localparam int IDX_W  = $clog2(NUM_LOOPS);
    localparam int RCNT_W = $clog2(REPETITIONS + 1);
    localparam int TMR_W  = timer_width(EVAL_TIME, RESET_TIME);

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_LOOPS - 1);
    localparam logic [RCNT_W-1:0] REP_LAST   = RCNT_W'(REPETITIONS - 1);
    localparam logic [TMR_W-1:0]  RESET_LOAD = TMR_W'(RESET_TIME - 1);
    localparam logic [TMR_W-1:0]  EVAL_LOAD  = TMR_W'(EVAL_TIME - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [RCNT_W-1:0]    r_rep;
    logic [RCNT_W-1:0]    w_rep_nxt;
    logic [NUM_LOOPS-1:0] r_chal;
    logic [NUM_LOOPS-1:0] w_chal_nxt;
    logic                 w_tmr_load;
    logic                 w_tmr_en;
    logic [TMR_W-1:0]     w_tmr_value;
    logic                 w_tmr_zero;
    logic                 w_busy;

    tero_phase_timer #(
        .WIDTH (TMR_W)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_tmr_load),
        .en    (w_tmr_en),
        .value (w_tmr_value),
        .zero  (w_tmr_zero)
    );

    // State, loop index, repetition count and latched challenge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_rep   <= '0;
            r_chal  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_rep   <= w_rep_nxt;
            r_chal  <= w_chal_nxt;
        end
    end

    // Next-state, counter updates and phase timer control
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep;
        w_chal_nxt  = r_chal;
        w_tmr_load  = 1'b0;
        w_tmr_en    = 1'b0;
        w_tmr_value = RESET_LOAD;

        if (abort) begin
            // Abort outranks start and next_enable; in IDLE it just blocks start
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_rep_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_chal_nxt  = challenge;
                        w_idx_nxt   = '0;
                        w_rep_nxt   = '0;
                        w_state_nxt = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (r_chal[r_idx]) begin
                        w_state_nxt = ST_RESET;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = RESET_LOAD;
                    end else if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
                ST_RESET: begin
                    if (w_tmr_zero) begin
                        w_state_nxt = ST_EVAL;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = EVAL_LOAD;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (w_tmr_zero) begin
                        w_state_nxt = ST_SAMPLE;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (next_enable == AVG_READY) begin
                        if (r_rep != REP_LAST) begin
                            w_rep_nxt   = r_rep + RCNT_W'(1);
                            w_state_nxt = ST_RESET;
                            w_tmr_load  = 1'b1;
                            w_tmr_value = RESET_LOAD;
                        end else begin
                            w_rep_nxt = '0;
                            if (r_idx == IDX_LAST) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_idx_nxt   = r_idx + IDX_W'(1);
                                w_state_nxt = ST_SCAN;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_rep_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so nothing combinational reaches them from inputs
    assign w_busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign busy             = w_busy;
    assign done             = (r_state == ST_DONE);
    assign reset_puf        = (r_state == ST_RESET);
    assign enable_puf       = (r_state == ST_EVAL);
    assign add_response_puf = (r_state == ST_SAMPLE);
    assign last_rep         = (r_state == ST_SAMPLE) && (r_rep == REP_LAST);
    assign select_puf       = w_busy ? r_idx : '0;
    assign rep_index        = w_busy ? r_rep : '0;

endmodule

// File: tb/tb_tero_sequencer.sv
// Directed bench for tero_sequencer with a scoreboard of expected
// add_response_puf pulses (loop index, repetition, last flag).
module tb_tero_sequencer;
    import tero_pkg::*;

    localparam int NL   = 8;
    localparam int REPS = 4;
    localparam int ET   = 16;
    localparam int RT   = 2;

    typedef struct packed {
        logic [LOOP_W-1:0] sel;
        logic [REP_W-1:0]  rep;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [NL-1:0]     challenge = '0;
    logic              next_enable = 1'b0;
    logic              busy;
    logic              done;
    logic              reset_puf;
    logic              enable_puf;
    logic [LOOP_W-1:0] select_puf;
    logic              add_response_puf;
    logic [REP_W-1:0]  rep_index;
    logic              last_rep;

    exp_t sb_q[$];
    int   pulse_cyc[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   act_cnt = 0;

    tero_sequencer #(
        .NUM_LOOPS   (NL),
        .REPETITIONS (REPS),
        .EVAL_TIME   (ET),
        .RESET_TIME  (RT)
    ) dut (
        .clk              (clk),
        .reset            (rst_n),
        .start            (start),
        .abort            (abort),
        .challenge        (challenge),
        .next_enable      (next_enable),
        .busy             (busy),
        .done             (done),
        .reset_puf        (reset_puf),
        .enable_puf       (enable_puf),
        .select_puf       (select_puf),
        .add_response_puf (add_response_puf),
        .rep_index        (rep_index),
        .last_rep         (last_rep)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_loop(input int sel);
        for (int r = 0; r < REPS; r++)
            sb_q.push_back('{sel: LOOP_W'(sel), rep: REP_W'(r), last: 1'(r == REPS - 1)});
    endtask

    // Wait for the falling edge and score any pulse seen there
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (reset_puf || enable_puf || add_response_puf) act_cnt++;
        if (add_response_puf) begin
            pulse_cyc.push_back(cyc);
            check("sb_pulse_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_select", select_puf, e.sel);
                check("sb_rep", rep_index, e.rep);
                check("sb_last", last_rep, e.last);
                check("sb_no_phase", {reset_puf, enable_puf}, 2'b00);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return reset_puf;
            1:       return enable_puf;
            2:       return add_response_puf;
            default: return done;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int bound, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < bound; i++) begin
            sample();
            if (sig_sel(which)) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic count_high(input int which, input int bound, output int len);
        len = 1;
        for (int i = 0; i < bound; i++) begin
            sample();
            if (!sig_sel(which)) break;
            len++;
        end
    endtask

    task automatic pulse_start(output int t0);
        adv();
        start = 1'b1;
        t0 = cyc;
        adv();
        start = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {busy, done, reset_puf, enable_puf, select_puf, add_response_puf, rep_index, last_rep};
    endfunction

    initial begin
        bit ok;
        int t0, at, len, base, g1, g2, acts;

        // Reset
        #1 rst_n = 1'b0;
        sample();
        check("reset_outputs", all_outs(), 0);
        adv();
        rst_n = 1'b1;
        sample();
        check("idle_after_release", all_outs(), 0);

        // A: loops 0 and 2, averager always ready
        challenge   = 8'b0000_0101;
        next_enable = 1'b1;
        push_loop(0);
        push_loop(2);
        base = pulse_cyc.size();
        pulse_start(t0);
        wait_sig(0, 50, ok, at);
        check("a_reset_seen", ok, 1);
        check("a_first_reset_offset", at - t0, 2);
        count_high(0, 50, len);
        check("a_reset_len", len, RT);
        check("a_enable_follows", enable_puf, 1);
        count_high(1, 50, len);
        check("a_eval_len", len, ET);
        check("a_add_after_eval", add_response_puf, 1);
        wait_sig(3, 400, ok, at);
        check("a_done_seen", ok, 1);
        check("a_busy_low", busy, 0);
        check("a_pulse_count", pulse_cyc.size() - base, 8);
        g1 = (pulse_cyc.size() > base + 1) ? pulse_cyc[base + 1] - pulse_cyc[base] : -1;
        g2 = (pulse_cyc.size() > base + 4) ? pulse_cyc[base + 4] - pulse_cyc[base + 3] : -1;
        check("a_rep_period", g1, RT + ET + 2);
        check("a_loop_gap", g2, RT + ET + 4);
        check("a_sb_drained", sb_q.size(), 0);

        // B: empty mask
        challenge = '0;
        acts = act_cnt;
        base = pulse_cyc.size();
        pulse_start(t0);
        sample();
        check("b_done_cleared", done, 0);
        check("b_busy", busy, 1);
        wait_sig(3, 30, ok, at);
        check("b_done_seen", ok, 1);
        check("b_done_latency", at - t0, 9);
        check("b_no_activity", act_cnt - acts, 0);
        check("b_no_pulses", pulse_cyc.size() - base, 0);

        // C: loop 7, averager stalls 10 cycles after every sample
        challenge   = 8'h80;
        next_enable = 1'b0;
        push_loop(7);
        pulse_start(t0);
        for (int r = 0; r < REPS; r++) begin
            wait_sig(2, 200, ok, at);
            check("c_add_seen", ok, 1);
            repeat (10) begin
                adv();
                sample();
            end
            check("c_stall_select", select_puf, 7);
            check("c_stall_phases", {reset_puf, enable_puf, add_response_puf}, 3'b000);
            check("c_stall_busy", busy, 1);
            check("c_stall_rep", rep_index, r);
            adv();
            next_enable = 1'b1;
            sample();
            check("c_no_comb_path", reset_puf, 0);
            adv();
            next_enable = 1'b0;
            sample();
            if (r < REPS - 1) check("c_resume_reset", reset_puf, 1);
            else check("c_resume_done", done, 1);
        end
        check("c_sb_drained", sb_q.size(), 0);

        // D: abort in the 5th EVAL cycle of loop 3, then rerun
        challenge   = 8'h08;
        next_enable = 1'b1;
        pulse_start(t0);
        wait_sig(1, 100, ok, at);
        check("d_eval_seen", ok, 1);
        check("d_eval_select", select_puf, 3);
        repeat (4) adv();
        abort = 1'b1;
        sample();
        check("d_abort_registered", enable_puf, 1);
        adv();
        abort = 1'b0;
        sample();
        check("d_abort_outputs", all_outs(), 0);
        push_loop(3);
        pulse_start(t0);
        wait_sig(0, 50, ok, at);
        check("d_rerun_reset_seen", ok, 1);
        check("d_rerun_offset", at - t0, 5);
        wait_sig(3, 400, ok, at);
        check("d_rerun_done", ok, 1);
        check("d_sb_drained", sb_q.size(), 0);

        // E: start pulse and challenge change mid-run are ignored
        challenge = 8'b0000_0101;
        push_loop(0);
        push_loop(2);
        base = pulse_cyc.size();
        pulse_start(t0);
        wait_sig(0, 50, ok, at);
        check("e_reset_seen", ok, 1);
        adv();
        start     = 1'b1;
        challenge = 8'hFA;
        adv();
        start = 1'b0;
        wait_sig(3, 600, ok, at);
        check("e_done_seen", ok, 1);
        check("e_pulse_count", pulse_cyc.size() - base, 8);
        check("e_sb_drained", sb_q.size(), 0);

        // F: asynchronous reset in the middle of EVAL
        challenge = 8'h01;
        pulse_start(t0);
        wait_sig(1, 100, ok, at);
        check("f_eval_seen", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        check("f_async_outputs", all_outs(), 0);
        adv();
        adv();
        rst_n = 1'b1;
        repeat (5) begin
            adv();
            sample();
        end
        check("f_idle_after_reset", all_outs(), 0);
        check("f_sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
